modport_alu: RTL and testbench
==============================

# modport_alu

Registered 8-bit 8051-style arithmetic/logic unit. Each cycle it takes up to three byte operands, a bit operand and carry/aux-carry inputs, applies the operation selected by a 4-bit opcode, and registers a byte result, two auxiliary byte results and three flags. It sits between the CPU core's operand-select stage and the accumulator/PSW write-back stage.

## Interface
- Parameters: none; datapath is fixed at 8 bits.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- op_code  input  4  operation select.
- src1  input  8  operand A (accumulator).
- src2  input  8  operand B.
- src3  input  8  operand C (high byte for carry propagation).
- bit_in  input  1  bit operand for Boolean ops.
- srcCy  input  1  carry in.
- srcAc  input  1  auxiliary carry in.
- des_acc  output  8  primary result (accumulator write-back).
- des1  output  8  result low byte.
- des2  output  8  result high byte / secondary result.
- desCy  output  1  carry out.
- desAc  output  1  auxiliary carry out.
- desOv  output  1  overflow out.
- sub_result  output  8  always (src1 - src2) mod 256.

## Operation
- Defaults unless overridden below: des_acc=des1=result, des2=src2, desCy=srcCy, desAc=srcAc, desOv=0.
- 0 NOP: result=src1.
- 1 ADD: s=src1+src2+srcCy; result=s[7:0]; desCy=s[8]; desAc=carry out of bit 3; desOv=signed overflow; des2=src3+desCy.
- 2 SUB: d=src1-src2-srcCy; result=d[7:0]; desCy=borrow out of bit 7; desAc=borrow out of bit 3; desOv=signed overflow; des2=src3-desCy.
- 3 MUL: p=src1*src2; des_acc=des1=p[7:0]; des2=p[15:8]; desCy=0; desOv=(p[15:8]!=0).
- 4 DIV: des_acc=des1=src1/src2, des2=src1%src2, desCy=0, desOv=0. src2==0: des_acc=des1=8'hFF, des2=src1, desOv=1.
- 5 DA: low nibble >9 or srcAc → add 6; then high nibble >9, srcCy, or carry from low step → add 8'h60; desCy=srcCy OR any carry out of bit 7.
- 6 NOT: result=~src1; desCy=~srcCy.
- 7 AND: result=src1&src2; desCy=srcCy&bit_in.
- 8 XOR: result=src1^src2; desCy=srcCy^bit_in.
- 9 OR: result=src1|src2; desCy=srcCy|bit_in.
- 10 RL: result={src1[6:0],src1[7]}.
- 11 RLC: result={src1[6:0],srcCy}; desCy=src1[7].
- 12 RR: result={src1[0],src1[7:1]}.
- 13 RRC: result={srcCy,src1[7:1]}; desCy=src1[0].
- 14 INC16: {des2,des1}={src2,src1}+1; des_acc=des1; desCy=carry out of bit 15.
- 15 XCH: des_acc=des1=src2; des2=src1.
- sub_result is updated every cycle regardless of opcode.

## Timing
- All outputs are registered. Inputs sampled at rising edge N appear at outputs after edge N; latency 1 cycle, throughput 1 op/cycle. There is no handshake.
- Reset: rst high at a rising edge clears every output to 0 (bytes 8'h00, flags 0). Reset overrides any opcode.
- Mid-stream reset: the operation sampled at that edge is discarded. The first edge with rst low produces a normal result.
- No internal state beyond output registers. Back-to-back opcodes are independent.
- Divider and multiplier are combinational within one cycle.

## Configuration
- MODPORT_ALU_DIV_EN defined: opcode 4 behaves as specified above.
- MODPORT_ALU_DIV_EN undefined: no divider is synthesised. Opcode 4 gives des_acc=des1=src1, des2=src2, desCy=srcCy, desAc=srcAc, desOv=1, flagging an unsupported operation.

## Test plan
- Reset: rst=1 for 2 cycles with op=1, src1=src2=8'hFF → all outputs 0. Release rst → the next cycle shows the ADD result.
- ADD: src1=8'h7F, src2=8'h01, srcCy=0, src3=8'h10 → des_acc=8'h80, desCy=0, desAc=1, desOv=1, des2=8'h10. Then src1=8'hFF, src2=8'h01 → 8'h00, desCy=1, des2=8'h11.
- SUB/sub_result: src1=8'h00, src2=8'h01, srcCy=1 → des_acc=8'hFE, desCy=1, sub_result=8'hFF.
- MUL/DIV: 8'h10*8'h20 → des1=8'h00, des2=8'h02, desOv=1. 8'd100/8'd7 → des1=8'd14, des2=8'd2. Divide by 0 → desOv=1, des1=8'hFF. Repeat with MODPORT_ALU_DIV_EN undefined → desOv=1, des1=src1.
- DA: src1=8'h9A, srcAc=0, srcCy=0 → des_acc=8'h00, desCy=1.
- Rotate/Boolean/INC16/XCH: RLC with src1=8'h80, srcCy=0 → 8'h00, desCy=1. AND with srcCy=1, bit_in=0 → desCy=0. INC16 with src2=8'hFF, src1=8'hFF → des2=des1=8'h00, desCy=1. XCH with src1=8'hA5, src2=8'h3C → des_acc=8'h3C, des2=8'hA5.

Source files
------------

// File: rtl/modport_alu_if.sv
// modport_alu_if: operand/result bundle between the operand-select stage
// (master) and the registered 8051-style ALU (slave).
interface modport_alu_if;
    logic [3:0] op_code;
    logic [7:0] src1;
    logic [7:0] src2;
    logic [7:0] src3;
    logic       bit_in;
    logic       srcCy;
    logic       srcAc;
    logic [7:0] des_acc;
    logic [7:0] des1;
    logic [7:0] des2;
    logic       desCy;
    logic       desAc;
    logic       desOv;
    logic [7:0] sub_result;

    modport master (
        output op_code, src1, src2, src3, bit_in, srcCy, srcAc,
        input  des_acc, des1, des2, desCy, desAc, desOv, sub_result
    );

    modport slave (
        input  op_code, src1, src2, src3, bit_in, srcCy, srcAc,
        output des_acc, des1, des2, desCy, desAc, desOv, sub_result
    );
endinterface

// File: rtl/modport_alu.sv
// modport_alu: registered 8-bit 8051-style ALU, one op per cycle, latency 1.
// Optional feature macro: MODPORT_ALU_DIV_EN enables the combinational
// divider for opcode 4; without it opcode 4 passes operands through and
// raises desOv to flag an unsupported operation.
module modport_alu (
    input  logic               clk,
    input  logic               rst,
    modport_alu_if.slave       bus
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_MUL   = 4'd3,
        OP_DIV   = 4'd4,
        OP_DA    = 4'd5,
        OP_NOT   = 4'd6,
        OP_AND   = 4'd7,
        OP_XOR   = 4'd8,
        OP_OR    = 4'd9,
        OP_RL    = 4'd10,
        OP_RLC   = 4'd11,
        OP_RR    = 4'd12,
        OP_RRC   = 4'd13,
        OP_INC16 = 4'd14,
        OP_XCH   = 4'd15
    } op_e;

    logic [7:0] acc_q, acc_d;
    logic [7:0] d1_q, d1_d;
    logic [7:0] d2_q, d2_d;
    logic [7:0] sub_q, sub_d;
    logic       cy_q, cy_d;
    logic       ac_q, ac_d;
    logic       ov_q, ov_d;

    logic [8:0]  add_s;
    logic [4:0]  add_l;
    logic [8:0]  sub_s;
    logic [4:0]  sub_l;
    logic [15:0] mul_p;
    logic        da_lo_adj;
    logic        da_hi_adj;
    logic [8:0]  da_t1;
    logic [8:0]  da_t2;
    logic [16:0] inc_s;

    // Shared arithmetic; bit 8 / bit 4 of the widened sums give carry/borrow out.
    assign add_s = {1'b0, bus.src1} + {1'b0, bus.src2} + {8'b0, bus.srcCy};
    assign add_l = {1'b0, bus.src1[3:0]} + {1'b0, bus.src2[3:0]} + {4'b0, bus.srcCy};
    assign sub_s = {1'b0, bus.src1} - {1'b0, bus.src2} - {8'b0, bus.srcCy};
    assign sub_l = {1'b0, bus.src1[3:0]} - {1'b0, bus.src2[3:0]} - {4'b0, bus.srcCy};
    assign mul_p = {8'b0, bus.src1} * {8'b0, bus.src2};
    assign inc_s = {1'b0, bus.src2, bus.src1} + 17'd1;

    // Decimal adjust: the high-nibble decision looks at the low step's result
    // and its carry, so a low-nibble adjust can trigger the high one.
    assign da_lo_adj = (bus.src1[3:0] > 4'd9) | bus.srcAc;
    assign da_t1     = {1'b0, bus.src1} + (da_lo_adj ? 9'h006 : 9'h000);
    assign da_hi_adj = (da_t1[7:4] > 4'd9) | bus.srcCy | da_t1[8];
    assign da_t2     = {1'b0, da_t1[7:0]} + (da_hi_adj ? 9'h060 : 9'h000);

    // Next-state result selection; defaults pass src2/flags through.
    always_comb begin
        acc_d = bus.src1;
        d1_d  = bus.src1;
        d2_d  = bus.src2;
        cy_d  = bus.srcCy;
        ac_d  = bus.srcAc;
        ov_d  = 1'b0;
        sub_d = bus.src1 - bus.src2;
        case (op_e'(bus.op_code))
            OP_NOP: begin
                acc_d = bus.src1;
            end
            OP_ADD: begin
                acc_d = add_s[7:0];
                cy_d  = add_s[8];
                ac_d  = add_l[4];
                ov_d  = (bus.src1[7] == bus.src2[7]) && (add_s[7] != bus.src1[7]);
                d2_d  = bus.src3 + {7'b0, add_s[8]};
            end
            OP_SUB: begin
                acc_d = sub_s[7:0];
                cy_d  = sub_s[8];
                ac_d  = sub_l[4];
                ov_d  = (bus.src1[7] != bus.src2[7]) && (sub_s[7] != bus.src1[7]);
                d2_d  = bus.src3 - {7'b0, sub_s[8]};
            end
            OP_MUL: begin
                acc_d = mul_p[7:0];
                d2_d  = mul_p[15:8];
                cy_d  = 1'b0;
                ov_d  = (mul_p[15:8] != 8'h00);
            end
            OP_DIV: begin
`ifdef MODPORT_ALU_DIV_EN
                cy_d = 1'b0;
                if (bus.src2 == 8'h00) begin
                    acc_d = 8'hFF;
                    d2_d  = bus.src1;
                    ov_d  = 1'b1;
                end else begin
                    acc_d = bus.src1 / bus.src2;
                    d2_d  = bus.src1 % bus.src2;
                    ov_d  = 1'b0;
                end
`else
                acc_d = bus.src1;
                d2_d  = bus.src2;
                ov_d  = 1'b1;
`endif
            end
            OP_DA: begin
                acc_d = da_t2[7:0];
                cy_d  = bus.srcCy | da_t1[8] | da_t2[8];
            end
            OP_NOT: begin
                acc_d = ~bus.src1;
                cy_d  = ~bus.srcCy;
            end
            OP_AND: begin
                acc_d = bus.src1 & bus.src2;
                cy_d  = bus.srcCy & bus.bit_in;
            end
            OP_XOR: begin
                acc_d = bus.src1 ^ bus.src2;
                cy_d  = bus.srcCy ^ bus.bit_in;
            end
            OP_OR: begin
                acc_d = bus.src1 | bus.src2;
                cy_d  = bus.srcCy | bus.bit_in;
            end
            OP_RL: begin
                acc_d = {bus.src1[6:0], bus.src1[7]};
            end
            OP_RLC: begin
                acc_d = {bus.src1[6:0], bus.srcCy};
                cy_d  = bus.src1[7];
            end
            OP_RR: begin
                acc_d = {bus.src1[0], bus.src1[7:1]};
            end
            OP_RRC: begin
                acc_d = {bus.srcCy, bus.src1[7:1]};
                cy_d  = bus.src1[0];
            end
            OP_INC16: begin
                acc_d = inc_s[7:0];
                d2_d  = inc_s[15:8];
                cy_d  = inc_s[16];
            end
            OP_XCH: begin
                acc_d = bus.src2;
                d2_d  = bus.src1;
            end
            default: begin
                acc_d = bus.src1;
            end
        endcase
        d1_d = acc_d;
    end

    // Output registers; reset wins over any opcode sampled on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 8'h00;
            d1_q  <= 8'h00;
            d2_q  <= 8'h00;
            sub_q <= 8'h00;
            cy_q  <= 1'b0;
            ac_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            d1_q  <= d1_d;
            d2_q  <= d2_d;
            sub_q <= sub_d;
            cy_q  <= cy_d;
            ac_q  <= ac_d;
            ov_q  <= ov_d;
        end
    end

    assign bus.des_acc    = acc_q;
    assign bus.des1       = d1_q;
    assign bus.des2       = d2_q;
    assign bus.sub_result = sub_q;
    assign bus.desCy      = cy_q;
    assign bus.desAc      = ac_q;
    assign bus.desOv      = ov_q;

endmodule

// File: tb/tb_modport_alu.sv
// tb_modport_alu: table-driven check of modport_alu with an expected-result
// queue; expected vectors are hand-computed constants.
module tb_modport_alu;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    modport_alu_if bus ();

    modport_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected layout: {des_acc, des1, des2, sub_result, desCy, desAc, desOv}
    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] s1, s2, s3;
        logic       bi, cy, ac;
        logic [34:0] exp;
    } vec_t;

    vec_t         vecs[$];
    logic [34:0]  sb_q[$];
    string        sb_name[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    function automatic vec_t mk(string name, logic [3:0] op, logic [7:0] s1, logic [7:0] s2,
                                logic [7:0] s3, logic bi, logic cy, logic ac,
                                logic [7:0] e_acc, logic [7:0] e_d2, logic [7:0] e_sub,
                                logic e_cy, logic e_ac, logic e_ov);
        vec_t v;
        v.name = name; v.op = op; v.s1 = s1; v.s2 = s2; v.s3 = s3;
        v.bi = bi; v.cy = cy; v.ac = ac;
        v.exp = {e_acc, e_acc, e_d2, e_sub, e_cy, e_ac, e_ov};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.op_code = v.op;
        bus.src1    = v.s1;
        bus.src2    = v.s2;
        bus.src3    = v.s3;
        bus.bit_in  = v.bi;
        bus.srcCy   = v.cy;
        bus.srcAc   = v.ac;
        sb_q.push_back(v.exp);
        sb_name.push_back(v.name);
    endtask

    // Advance one edge, then pop the oldest expectation and compare.
    task automatic step();
        logic [34:0] got;
        logic [34:0] exp;
        string       nm;
        @(posedge clk);
        #1;
        got = {bus.des_acc, bus.des1, bus.des2, bus.sub_result, bus.desCy, bus.desAc, bus.desOv};
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty got=%h", got);
        end else begin
            exp = sb_q.pop_front();
            nm  = sb_name.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s got acc=%h d1=%h d2=%h sub=%h cy=%b ac=%b ov=%b exp acc=%h d1=%h d2=%h sub=%h cy=%b ac=%b ov=%b",
                         nm, got[34:27], got[26:19], got[18:11], got[10:3], got[2], got[1], got[0],
                         exp[34:27], exp[26:19], exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        vec_t v;

        //                 name         op  s1     s2     s3    bi cy ac   acc    d2     sub   cy ac ov
        vecs.push_back(mk("add_ov",     1, 8'h7F, 8'h01, 8'h10, 0, 0, 0, 8'h80, 8'h10, 8'h7E, 0, 1, 0) );
        vecs[$].exp[0] = 1'b1;
        vecs.push_back(mk("add_wrap",   1, 8'hFF, 8'h01, 8'h10, 0, 0, 0, 8'h00, 8'h11, 8'hFE, 1, 1, 0));
        vecs.push_back(mk("sub_borrow", 2, 8'h00, 8'h01, 8'h20, 0, 1, 0, 8'hFE, 8'h1F, 8'hFF, 1, 1, 0));
        vecs.push_back(mk("sub_ov",     2, 8'h80, 8'h01, 8'h00, 0, 0, 0, 8'h7F, 8'h00, 8'h7F, 0, 1, 1));
        vecs.push_back(mk("mul_hi",     3, 8'h10, 8'h20, 8'h55, 0, 1, 1, 8'h00, 8'h02, 8'hF0, 0, 1, 1));
        vecs.push_back(mk("mul_lo",     3, 8'h03, 8'h04, 8'h00, 0, 0, 0, 8'h0C, 8'h00, 8'hFF, 0, 0, 0));
`ifdef MODPORT_ALU_DIV_EN
        vecs.push_back(mk("div",        4, 8'd100, 8'd7, 8'h00, 0, 1, 0, 8'd14, 8'd2, 8'h5D, 0, 0, 0));
        vecs.push_back(mk("div_zero",   4, 8'h55, 8'h00, 8'h00, 0, 0, 1, 8'hFF, 8'h55, 8'h55, 0, 1, 1));
`else
        vecs.push_back(mk("div_off",    4, 8'd100, 8'd7, 8'h00, 0, 1, 0, 8'd100, 8'd7, 8'h5D, 1, 0, 1));
        vecs.push_back(mk("div_off_z",  4, 8'h55, 8'h00, 8'h00, 0, 0, 1, 8'h55, 8'h00, 8'h55, 0, 1, 1));
`endif
        vecs.push_back(mk("da_9a",      5, 8'h9A, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h9A, 1, 0, 0));
        vecs.push_back(mk("da_ac",      5, 8'h15, 8'h00, 8'h00, 0, 0, 1, 8'h1B, 8'h00, 8'h15, 0, 1, 0));
        vecs.push_back(mk("not",        6, 8'h5A, 8'h33, 8'h00, 0, 1, 0, 8'hA5, 8'h33, 8'h27, 0, 0, 0));
        vecs.push_back(mk("and",        7, 8'hF0, 8'h3C, 8'h00, 0, 1, 0, 8'h30, 8'h3C, 8'hB4, 0, 0, 0));
        vecs.push_back(mk("xor",        8, 8'hF0, 8'h3C, 8'h00, 1, 1, 0, 8'hCC, 8'h3C, 8'hB4, 0, 0, 0));
        vecs.push_back(mk("or",         9, 8'hF0, 8'h3C, 8'h00, 1, 0, 0, 8'hFC, 8'h3C, 8'hB4, 1, 0, 0));
        vecs.push_back(mk("rl",        10, 8'h81, 8'h00, 8'h00, 0, 0, 0, 8'h03, 8'h00, 8'h81, 0, 0, 0));
        vecs.push_back(mk("rlc",       11, 8'h80, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h80, 1, 0, 0));
        vecs.push_back(mk("rr",        12, 8'h01, 8'h00, 8'h00, 0, 0, 0, 8'h80, 8'h00, 8'h01, 0, 0, 0));
        vecs.push_back(mk("rrc",       13, 8'h01, 8'h00, 8'h00, 0, 1, 0, 8'h80, 8'h00, 8'h01, 1, 0, 0));
        vecs.push_back(mk("inc16_wrap",14, 8'hFF, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0));
        vecs.push_back(mk("inc16",     14, 8'h12, 8'h34, 8'h00, 0, 1, 0, 8'h13, 8'h34, 8'hDE, 0, 0, 0));
        vecs.push_back(mk("xch",       15, 8'hA5, 8'h3C, 8'h00, 0, 0, 0, 8'h3C, 8'hA5, 8'h69, 0, 0, 0));
        vecs.push_back(mk("nop",        0, 8'h42, 8'h11, 8'h00, 0, 1, 1, 8'h42, 8'h11, 8'h31, 1, 1, 0));

        // Reset held two cycles with an ADD pending: outputs stay cleared.
        rst = 1'b1;
        v = mk("reset", 1, 8'hFF, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        drive(v);
        step();
        drive(v);
        step();
        // First edge with rst low: FF+FF = 1FE.
        rst = 1'b0;
        drive(mk("post_reset_add", 1, 8'hFF, 8'hFF, 8'h00, 0, 0, 0, 8'hFE, 8'h01, 8'h00, 1, 1, 0));
        step();

        // Back-to-back table vectors, one per cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            step();
        end

        // Mid-stream reset discards the op on that edge; the next op is normal.
        rst = 1'b1;
        drive(mk("mid_reset", 15, 8'hA5, 8'h3C, 8'h00, 0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        step();
        rst = 1'b0;
        drive(mk("after_mid_reset", 6, 8'h0F, 8'h01, 8'h00, 0, 0, 1, 8'hF0, 8'h01, 8'h0E, 1, 1, 0));
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
